// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial two's-complement subtractor: diff = x - y, computed one bit per
// clock, LSB first, over maxn cycles. It is the small-footprint companion of
// the ripple-carry adder in the same datapath library.
//
// Handshake: start is sampled only in IDLE or DONE. The accepting edge
// captures x and y. busy is high for exactly maxn cycles, then done pulses
// for one cycle with the result and flags valid. A start held high during
// the done cycle begins the next operation immediately, giving one result
// every maxn+1 cycles.
//
// Ports:
//   clk       in   clock; all state changes on the rising edge
//   rst       in   synchronous, active-high reset (highest priority)
//   start     in   request a subtraction (ignored while busy)
//   x         in   minuend, maxn bits
//   y         in   subtrahend, maxn bits
//   busy      out  high while bits are being processed
//   done      out  one-cycle pulse when diff and the flags are updated
//   diff      out  x - y modulo 2^maxn
//   borrow    out  unsigned borrow out of bit maxn-1 (x < y)
//   zero      out  diff == 0
//   overflow  out  signed overflow of x - y
//
// The result and flags registers change only when the last bit completes,
// or on reset. They hold their values through IDLE and the next RUN.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int maxn = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [maxn-1:0] x,
  input  logic [maxn-1:0] y,
  output logic            busy,
  output logic            done,
  output logic [maxn-1:0] diff,
  output logic            borrow,
  output logic            zero,
  output logic            overflow
);

  // The counter must be able to hold maxn itself.
  localparam int CW = $clog2(maxn + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(maxn - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q,    state_d;
  logic [maxn-1:0] a_q,        a_d;        // minuend shift register
  logic [maxn-1:0] b_q,        b_d;        // subtrahend shift register
  logic [maxn-1:0] res_q,      res_d;      // partial result, filled from the MSB
  logic [CW-1:0]   count_q,    count_d;
  logic            br_q,       br_d;       // running borrow between bit slices
  logic            xmsb_q,     xmsb_d;     // operand sign bits, kept for overflow
  logic            ymsb_q,     ymsb_d;
  logic [maxn-1:0] diff_q,     diff_d;
  logic            borrow_q,   borrow_d;
  logic            zero_q,     zero_d;
  logic            overflow_q, overflow_d;

  // One-bit full-subtractor slice on the current LSBs.
  logic            bit_a;
  logic            bit_b;
  logic            bit_d;
  logic            br_next;
  logic [maxn-1:0] res_full;

  always_comb begin
    bit_a    = a_q[0];
    bit_b    = b_q[0];
    bit_d    = bit_a ^ bit_b ^ br_q;
    br_next  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
    // Result with the current bit shifted in; on the last bit this is the
    // complete difference.
    res_full = {bit_d, res_q[maxn-1:1]};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    count_d    = count_q;
    br_d       = br_q;
    xmsb_d     = xmsb_q;
    ymsb_d     = ymsb_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;

    unique case (state_q)
      // DONE accepts a new request exactly like IDLE, which is what allows
      // back-to-back operations without a bubble cycle.
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = x;
          b_d     = y;
          res_d   = '0;
          count_d = '0;
          br_d    = 1'b0;
          xmsb_d  = x[maxn-1];
          ymsb_d  = y[maxn-1];
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        a_d     = {1'b0, a_q[maxn-1:1]};
        b_d     = {1'b0, b_q[maxn-1:1]};
        res_d   = res_full;
        br_d    = br_next;
        count_d = count_q + 1'b1;
        if (count_q == LAST_BIT) begin
          diff_d     = res_full;
          borrow_d   = br_next;
          zero_d     = (res_full == '0);
          // Signed overflow only possible when operand signs differ; it
          // happened if the result sign disagrees with the minuend sign.
          overflow_d = (xmsb_q != ymsb_q) && (res_full[maxn-1] != xmsb_q);
          state_d    = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      count_q    <= '0;
      br_q       <= 1'b0;
      xmsb_q     <= 1'b0;
      ymsb_q     <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      count_q    <= count_d;
      br_q       <= br_d;
      xmsb_q     <= xmsb_d;
      ymsb_q     <= ymsb_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor (maxn = 16). Each scenario task
// drives stimulus, pushes the expected result to a scoreboard queue when an
// operation is issued, and pops/compares when done is observed. Outputs are
// sampled on the falling clock edge; inputs change 1 time unit after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         borrow;
  logic         zero;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [N-1:0] d;
    logic         b;
    logic         z;
    logic         v;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;

  serial_subtractor #(.maxn(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x        (x),
    .y        (y),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .zero     (zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: plain wide arithmetic.
  function automatic exp_t model(input logic [N-1:0] xa, input logic [N-1:0] ya);
    exp_t        e;
    logic [N:0]  wide;
    wide = {1'b0, xa} - {1'b0, ya};
    e.d  = wide[N-1:0];
    e.b  = wide[N];
    e.z  = (wide[N-1:0] == '0);
    e.v  = (xa[N-1] != ya[N-1]) && (wide[N-1] != xa[N-1]);
    return e;
  endfunction

  // Present one request and let it be accepted; returns 1 unit after the
  // accepting edge with start released.
  task automatic issue(input logic [N-1:0] xa, input logic [N-1:0] ya, input bit track);
    @(posedge clk); #1;
    x = xa; y = ya; start = 1'b1;
    if (track) sb.push_back(model(xa, ya));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Observe falling edges until done, bounded by limit.
  task automatic wait_done(input int limit, output bit seen, output int cycles,
                           output int busy_cycles);
    seen = 1'b0; cycles = 0; busy_cycles = 0;
    while (!seen && cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (busy) busy_cycles++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; x = 16'h1234; y = 16'h0001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, diff, borrow, zero, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b diff=%h b=%b z=%b v=%b expected all 0",
               busy, done, diff, borrow, zero, overflow);
    end
    start = 1'b0; rst = 1'b0;
    $display("reset: outputs cleared");
  endtask

  task automatic test_basic();
    logic [N-1:0] xs [6] = '{16'h0005, 16'h0003, 16'h0000, 16'h1234, 16'h8000, 16'h7FFF};
    logic [N-1:0] ys [6] = '{16'h0003, 16'h0005, 16'h0001, 16'h1234, 16'h0001, 16'hFFFF};
    bit   seen;
    int   cyc, bcyc;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      issue(xs[i], ys[i], 1'b1);
      wait_done(40, seen, cyc, bcyc);
      checks++;
      if (!seen || cyc != 17) begin
        errors++;
        $display("FAIL basic_latency[%0d] got seen=%b cycles=%0d expected seen=1 cycles=17", i, seen, cyc);
      end
      checks++;
      if (bcyc != N) begin
        errors++;
        $display("FAIL basic_busy_len[%0d] got %0d expected %0d", i, bcyc, N);
      end
      e = sb.pop_front();
      checks++;
      if ({diff, borrow, zero, overflow} !== {e.d, e.b, e.z, e.v}) begin
        errors++;
        $display("FAIL basic_result[%0d] got diff=%h b=%b z=%b v=%b expected diff=%h b=%b z=%b v=%b",
                 i, diff, borrow, zero, overflow, e.d, e.b, e.z, e.v);
      end
      $display("basic: %h - %h -> diff=%h b=%b z=%b v=%b", xs[i], ys[i], diff, borrow, zero, overflow);
      last_exp = e;
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL basic_done_pulse[%0d] got done=%b on the cycle after done expected 0", i, done);
      end
    end
    // Results hold while idle.
    repeat (5) @(negedge clk);
    checks++;
    if ({diff, borrow, zero, overflow} !== {last_exp.d, last_exp.b, last_exp.z, last_exp.v}) begin
      errors++;
      $display("FAIL basic_hold got diff=%h b=%b z=%b v=%b expected diff=%h b=%b z=%b v=%b",
               diff, borrow, zero, overflow, last_exp.d, last_exp.b, last_exp.z, last_exp.v);
    end
  endtask

  task automatic test_ignore_and_back_to_back();
    bit   seen;
    int   cyc, bcyc;
    exp_t e;
    issue(16'h0010, 16'h0001, 1'b1);
    repeat (5) @(negedge clk);
    // Previous result still held during RUN.
    checks++;
    if ({diff, borrow, zero, overflow} !== {last_exp.d, last_exp.b, last_exp.z, last_exp.v}) begin
      errors++;
      $display("FAIL hold_during_run got diff=%h expected %h", diff, last_exp.d);
    end
    // Start pulse with different operands while busy: must be ignored.
    x = 16'hAAAA; y = 16'h5555; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    // Hold start with the next operands through the done cycle.
    x = 16'h0100; y = 16'h0001; start = 1'b1;
    sb.push_back(model(16'h0100, 16'h0001));
    wait_done(40, seen, cyc, bcyc);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ignore_done_seen got seen=0 expected 1");
    end
    e = sb.pop_front();
    checks++;
    if ({diff, borrow, zero, overflow} !== {e.d, e.b, e.z, e.v}) begin
      errors++;
      $display("FAIL ignore_result got diff=%h b=%b z=%b v=%b expected diff=%h b=%b z=%b v=%b",
               diff, borrow, zero, overflow, e.d, e.b, e.z, e.v);
    end
    $display("ignore: 0010 - 0001 -> diff=%h", diff);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40, seen, cyc, bcyc);
    checks++;
    if (!seen || cyc != 17 || bcyc != N) begin
      errors++;
      $display("FAIL b2b_latency got seen=%b cycles=%0d busy=%0d expected seen=1 cycles=17 busy=%0d",
               seen, cyc, bcyc, N);
    end
    e = sb.pop_front();
    checks++;
    if ({diff, borrow, zero, overflow} !== {e.d, e.b, e.z, e.v}) begin
      errors++;
      $display("FAIL b2b_result got diff=%h b=%b z=%b v=%b expected diff=%h b=%b z=%b v=%b",
               diff, borrow, zero, overflow, e.d, e.b, e.z, e.v);
    end
    $display("b2b: 0100 - 0001 -> diff=%h", diff);
  endtask

  task automatic test_reset_abort();
    bit   seen;
    int   cyc, bcyc;
    exp_t e;
    issue(16'h00FF, 16'h0001, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, diff, borrow, zero, overflow} !== '0) begin
      errors++;
      $display("FAIL abort_state got busy=%b done=%b diff=%h b=%b z=%b v=%b expected all 0",
               busy, done, diff, borrow, zero, overflow);
    end
    wait_done(25, seen, cyc, bcyc);
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_done got done after %0d cycles expected none", cyc);
    end
    $display("abort: reset mid-operation, diff=%h", diff);
    issue(16'h0002, 16'h0001, 1'b1);
    wait_done(40, seen, cyc, bcyc);
    checks++;
    if (!seen || cyc != 17) begin
      errors++;
      $display("FAIL abort_next_latency got seen=%b cycles=%0d expected seen=1 cycles=17", seen, cyc);
    end
    e = sb.pop_front();
    checks++;
    if ({diff, borrow, zero, overflow} !== {e.d, e.b, e.z, e.v}) begin
      errors++;
      $display("FAIL abort_next_result got diff=%h expected %h", diff, e.d);
    end
    $display("abort: 0002 - 0001 -> diff=%h", diff);
  endtask

  task automatic test_back_to_back();
    bit           seen;
    int           cyc, bcyc;
    int           issued;
    exp_t         e;
    logic [N-1:0] xr, yr;
    @(posedge clk); #1;
    xr = 16'($urandom); yr = 16'($urandom);
    x = xr; y = yr; start = 1'b1;
    sb.push_back(model(xr, yr));
    @(posedge clk); #1;
    issued = 1;
    for (int k = 0; k < 1000; k++) begin
      if (issued < 1000) begin
        xr = 16'($urandom);
        yr = ($urandom_range(0, 7) == 0) ? xr : 16'($urandom);
        x = xr; y = yr;
        sb.push_back(model(xr, yr));
        issued++;
      end else begin
        start = 1'b0;
      end
      wait_done(40, seen, cyc, bcyc);
      checks++;
      if (!seen || cyc != 17) begin
        errors++;
        $display("FAIL sweep_spacing[%0d] got seen=%b cycles=%0d expected seen=1 cycles=17", k, seen, cyc);
      end
      e = sb.pop_front();
      checks++;
      if ({diff, borrow, zero, overflow} !== {e.d, e.b, e.z, e.v}) begin
        errors++;
        $display("FAIL sweep_result[%0d] got diff=%h b=%b z=%b v=%b expected diff=%h b=%b z=%b v=%b",
                 k, diff, borrow, zero, overflow, e.d, e.b, e.z, e.v);
      end
      $display("sweep[%0d]: diff=%h b=%b z=%b v=%b", k, diff, borrow, zero, overflow);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; x = '0; y = '0;
    test_reset();
    test_basic();
    test_ignore_and_back_to_back();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
